// File: rtl/drum_game_ctrl_if.sv
// Board-side and timer-side signal bundle for drum_game_ctrl.
// The slave modport is the controller's view; master is the driver/observer view.
interface drum_game_ctrl_if;
  logic       start_i;
  logic       hat_hit_i;
  logic       cymbal_hit_i;
  logic       tom_hit_i;
  logic [5:0] seconds_i;
  logic       timer_reset_o;
  logic       timer_enable_o;
  logic [1:0] prompt_o;
  logic [2:0] hit_o;
  logic [7:0] score_o;
  logic [7:0] miss_o;
  logic [1:0] state_o;
  logic       game_over_o;

  modport slave (
    input  start_i, hat_hit_i, cymbal_hit_i, tom_hit_i, seconds_i,
    output timer_reset_o, timer_enable_o, prompt_o, hit_o, score_o, miss_o,
           state_o, game_over_o
  );

  modport master (
    output start_i, hat_hit_i, cymbal_hit_i, tom_hit_i, seconds_i,
    input  timer_reset_o, timer_enable_o, prompt_o, hit_o, score_o, miss_o,
           state_o, game_over_o
  );
endinterface

// File: rtl/drum_game_ctrl.sv
// Drum game sequencer: debounced pads, fixed-priority hit arbiter, LFSR prompts, round FSM.
// Optional macro DRUM_PENALTY_EN: a wrong-drum hit in PLAY decrements the score (floor 0).
module drum_game_ctrl #(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int ROUND_SECONDS   = 30,
  parameter int PROMPT_CYCLES   = 50000000
) (
  input  logic            clk,
  input  logic            reset,
  drum_game_ctrl_if.slave bus
);
  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int PW = $clog2(PROMPT_CYCLES + 1);
  localparam logic [DW-1:0] DB_LAST     = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [PW-1:0] PT_LAST     = PW'(PROMPT_CYCLES - 1);
  localparam logic [5:0]    ROUND_LIMIT = 6'(ROUND_SECONDS);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ARM  = 2'd1,
    S_PLAY = 2'd2,
    S_OVER = 2'd3
  } state_t;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

`ifdef DRUM_PENALTY_EN
  function automatic logic [7:0] sat_dec(input logic [7:0] v);
    return (v == 8'h00) ? v : v - 8'd1;
  endfunction
`endif

  // Input bit order: 0 hat, 1 cymbal, 2 tom, 3 start
  logic [3:0]    w_raw;
  logic [3:0]    r_sync1;
  logic [3:0]    r_sync2;
  logic [3:0]    r_deb;
  logic [3:0]    r_deb_d;
  logic [DW-1:0] r_db_cnt [4];
  logic [3:0]    w_ev;
  logic [2:0]    w_win;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [3:0]    r_lfsr;
  logic [1:0]    w_new_prompt;
  logic [1:0]    r_prompt;
  logic [1:0]    w_prompt_nxt;
  logic [2:0]    w_prompt_hot;
  logic [2:0]    r_hit;
  logic [7:0]    r_score;
  logic [7:0]    w_score_nxt;
  logic [7:0]    r_miss;
  logic [7:0]    w_miss_nxt;
  logic [PW-1:0] r_ptmr;
  logic [PW-1:0] w_ptmr_nxt;
  logic          r_tmr_rst;
  logic          r_tmr_en;
  logic          r_over;
  logic          w_correct;
  logic          w_round_end;
`ifdef DRUM_PENALTY_EN
  logic          w_wrong;
`endif

  assign w_raw = {bus.start_i, bus.tom_hit_i, bus.cymbal_hit_i, bus.hat_hit_i};

  // Stage: two-flop synchronizer and debounce counters
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_deb   <= '0;
      r_deb_d <= '0;
      for (int i = 0; i < 4; i++) r_db_cnt[i] <= '0;
    end else begin
      r_sync1 <= w_raw;
      r_sync2 <= r_sync1;
      r_deb_d <= r_deb;
      for (int i = 0; i < 4; i++) begin
        if (r_sync2[i] == r_deb[i]) begin
          r_db_cnt[i] <= '0;
        end else if (r_db_cnt[i] == DB_LAST) begin
          r_deb[i]    <= r_sync2[i];
          r_db_cnt[i] <= '0;
        end else begin
          r_db_cnt[i] <= r_db_cnt[i] + DW'(1);
        end
      end
    end
  end

  assign w_ev = r_deb & ~r_deb_d;

  always_comb begin
    w_win = 3'b000;
    if (w_ev[0])      w_win = 3'b001;
    else if (w_ev[1]) w_win = 3'b010;
    else if (w_ev[2]) w_win = 3'b100;
  end

  always_comb begin
    w_prompt_hot = 3'b000;
    case (r_prompt)
      2'd1:    w_prompt_hot = 3'b001;
      2'd2:    w_prompt_hot = 3'b010;
      2'd3:    w_prompt_hot = 3'b100;
      default: w_prompt_hot = 3'b000;
    endcase
  end

  assign w_new_prompt = 2'(r_lfsr % 4'd3) + 2'd1;
  assign w_correct    = (r_hit != 3'b000) && (r_hit == w_prompt_hot);
  assign w_round_end  = (bus.seconds_i >= ROUND_LIMIT);
`ifdef DRUM_PENALTY_EN
  assign w_wrong      = (r_hit != 3'b000) && !w_correct;
`endif

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Round-end wins over hits and timeouts; a hit wins over a same-cycle timeout
  always_comb begin
    w_state_nxt  = r_state;
    w_score_nxt  = r_score;
    w_miss_nxt   = r_miss;
    w_prompt_nxt = r_prompt;
    w_ptmr_nxt   = r_ptmr;
    case (r_state)
      S_IDLE: begin
        w_prompt_nxt = 2'd0;
        if (w_ev[3]) w_state_nxt = S_ARM;
      end
      S_ARM: begin
        w_score_nxt  = 8'd0;
        w_miss_nxt   = 8'd0;
        w_ptmr_nxt   = '0;
        w_prompt_nxt = w_new_prompt;
        w_state_nxt  = S_PLAY;
      end
      S_PLAY: begin
        if (w_round_end) begin
          w_state_nxt  = S_OVER;
          w_prompt_nxt = 2'd0;
        end else if (w_correct) begin
          w_score_nxt  = sat_inc(r_score);
          w_prompt_nxt = w_new_prompt;
          w_ptmr_nxt   = '0;
        end else begin
`ifdef DRUM_PENALTY_EN
          if (w_wrong) w_score_nxt = sat_dec(r_score);
`endif
          if (r_ptmr == PT_LAST) begin
            w_miss_nxt   = sat_inc(r_miss);
            w_prompt_nxt = w_new_prompt;
            w_ptmr_nxt   = '0;
          end else begin
            w_ptmr_nxt = r_ptmr + PW'(1);
          end
        end
      end
      S_OVER: begin
        w_prompt_nxt = 2'd0;
        if (w_ev[3]) w_state_nxt = S_ARM;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Stage: registered datapath and outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      r_lfsr    <= 4'b1001;
      r_hit     <= 3'b000;
      r_score   <= 8'd0;
      r_miss    <= 8'd0;
      r_prompt  <= 2'd0;
      r_ptmr    <= '0;
      r_tmr_rst <= 1'b1;
      r_tmr_en  <= 1'b0;
      r_over    <= 1'b0;
    end else begin
      r_lfsr    <= {r_lfsr[2:0], r_lfsr[3] ^ r_lfsr[2]};
      r_hit     <= (r_state == S_PLAY) ? w_win : 3'b000;
      r_score   <= w_score_nxt;
      r_miss    <= w_miss_nxt;
      r_prompt  <= w_prompt_nxt;
      r_ptmr    <= w_ptmr_nxt;
      r_tmr_rst <= (w_state_nxt == S_IDLE) || (w_state_nxt == S_ARM);
      r_tmr_en  <= (w_state_nxt == S_PLAY);
      r_over    <= (w_state_nxt == S_OVER);
    end
  end

  assign bus.timer_reset_o  = r_tmr_rst;
  assign bus.timer_enable_o = r_tmr_en;
  assign bus.prompt_o       = r_prompt;
  assign bus.hit_o          = r_hit;
  assign bus.score_o        = r_score;
  assign bus.miss_o         = r_miss;
  assign bus.state_o        = r_state;
  assign bus.game_over_o    = r_over;
endmodule

// File: tb/tb_drum_game_ctrl.sv
// Directed bench for drum_game_ctrl with DEBOUNCE_CYCLES=4, PROMPT_CYCLES=100, ROUND_SECONDS=30.
module tb_drum_game_ctrl;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  drum_game_ctrl_if bus();

  drum_game_ctrl #(
    .DEBOUNCE_CYCLES(4),
    .ROUND_SECONDS  (30),
    .PROMPT_CYCLES  (100)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int exp_score = 0;
  localparam logic [25:0] RESET_VEC = {2'd0, 1'b1, 1'b0, 2'd0, 3'd0, 8'd0, 8'd0, 1'b0};

  // Reference prompt source: x^4+x^3+1 Fibonacci LFSR seeded 1001 by reset
  logic [3:0] m_lfsr, m_prev;
  always @(posedge clk) begin
    m_prev <= m_lfsr;
    if (reset) m_lfsr <= 4'b1001;
    else       m_lfsr <= {m_lfsr[2:0], m_lfsr[3] ^ m_lfsr[2]};
  end

  function automatic logic [1:0] model_prompt(input logic [3:0] l);
    logic [3:0] r;
    r = l % 4'd3;
    return r[1:0] + 2'd1;
  endfunction

  function automatic logic [2:0] pad_of(input logic [1:0] p);
    case (p)
      2'd1:    return 3'b001;
      2'd2:    return 3'b010;
      2'd3:    return 3'b100;
      default: return 3'b000;
    endcase
  endfunction

  function automatic logic [25:0] out_vec();
    return {bus.state_o, bus.timer_reset_o, bus.timer_enable_o, bus.prompt_o,
            bus.hit_o, bus.score_o, bus.miss_o, bus.game_over_o};
  endfunction

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Hold pads {tom,cymbal,hat} 8 cycles then release 8; sample hit/score timing
  task automatic strike(input logic [2:0] pads, output logic [2:0] h_early, output logic [2:0] h_at,
                        output logic [7:0] sc, output logic [1:0] pr, output logic [1:0] pr_exp);
    @(negedge clk);
    {bus.tom_hit_i, bus.cymbal_hit_i, bus.hat_hit_i} = pads;
    repeat (6) @(posedge clk);
    @(negedge clk); h_early = bus.hit_o;
    @(posedge clk);
    @(negedge clk); h_at = bus.hit_o;
    @(posedge clk);
    @(negedge clk); sc = bus.score_o; pr = bus.prompt_o; pr_exp = model_prompt(m_prev);
    {bus.tom_hit_i, bus.cymbal_hit_i, bus.hat_hit_i} = 3'b000;
    repeat (8) @(posedge clk);
  endtask

  task automatic start_round(output logic [1:0] st6, output logic [1:0] st7, output logic tr7,
                             output logic [1:0] st8, output logic tr8, output logic te8,
                             output logic [1:0] pr8, output logic [1:0] pe8);
    @(negedge clk);
    bus.start_i = 1'b1;
    repeat (6) @(posedge clk);
    @(negedge clk); st6 = bus.state_o;
    @(posedge clk);
    @(negedge clk); st7 = bus.state_o; tr7 = bus.timer_reset_o;
    @(posedge clk);
    @(negedge clk); st8 = bus.state_o; tr8 = bus.timer_reset_o; te8 = bus.timer_enable_o;
    pr8 = bus.prompt_o; pe8 = model_prompt(m_prev);
    repeat (2) @(posedge clk);
    @(negedge clk);
    bus.start_i = 1'b0;
  endtask

  task automatic test_reset();
    logic [25:0] v;
    reset = 1'b1;
    bus.start_i = 1'b0; bus.hat_hit_i = 1'b0; bus.cymbal_hit_i = 1'b0; bus.tom_hit_i = 1'b0;
    bus.seconds_i = 6'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    v = out_vec();
    n_tests++; if (v !== RESET_VEC) begin n_fail++; $display("FAIL reset_values: got %h expected %h", v, RESET_VEC); end
    reset = 1'b0;
  endtask

  task automatic test_start();
    logic [1:0] st6, st7, st8, pr8, pe8;
    logic tr7, tr8, te8;
    start_round(st6, st7, tr7, st8, tr8, te8, pr8, pe8);
    n_tests++; if (st6 !== 2'd0) begin n_fail++; $display("FAIL start_idle_hold: got %0d expected 0", st6); end
    n_tests++; if (st7 !== 2'd1) begin n_fail++; $display("FAIL start_arm: got %0d expected 1", st7); end
    n_tests++; if (tr7 !== 1'b1) begin n_fail++; $display("FAIL start_arm_treset: got %0d expected 1", tr7); end
    n_tests++; if (st8 !== 2'd2) begin n_fail++; $display("FAIL start_play: got %0d expected 2", st8); end
    n_tests++; if (tr8 !== 1'b0) begin n_fail++; $display("FAIL start_play_treset: got %0d expected 0", tr8); end
    n_tests++; if (te8 !== 1'b1) begin n_fail++; $display("FAIL start_play_tenable: got %0d expected 1", te8); end
    n_tests++; if (pr8 !== pe8) begin n_fail++; $display("FAIL start_prompt: got %0d expected %0d", pr8, pe8); end
  endtask

  // PLAY began 2 edges before start_round returned, so the timeout lands 98 edges later
  task automatic test_miss();
    logic [1:0] pe;
    repeat (97) @(posedge clk);
    @(negedge clk);
    n_tests++; if (bus.miss_o !== 8'd0) begin n_fail++; $display("FAIL miss_early: got %0d expected 0", bus.miss_o); end
    @(posedge clk);
    @(negedge clk);
    pe = model_prompt(m_prev);
    n_tests++; if (bus.miss_o !== 8'd1) begin n_fail++; $display("FAIL miss_count: got %0d expected 1", bus.miss_o); end
    n_tests++; if (bus.prompt_o !== pe) begin n_fail++; $display("FAIL miss_prompt: got %0d expected %0d", bus.prompt_o, pe); end
  endtask

  task automatic test_hit();
    logic [2:0] he, ha, pads;
    logic [7:0] sc;
    logic [1:0] pr, pe;
    pads = pad_of(bus.prompt_o);
    strike(pads, he, ha, sc, pr, pe);
    exp_score = exp_score + 1;
    n_tests++; if (he !== 3'b000) begin n_fail++; $display("FAIL hit_early: got %b expected 000", he); end
    n_tests++; if (ha !== pads) begin n_fail++; $display("FAIL hit_pulse: got %b expected %b", ha, pads); end
    n_tests++; if (sc !== 8'(exp_score)) begin n_fail++; $display("FAIL hit_score: got %0d expected %0d", sc, exp_score); end
    n_tests++; if (pr !== pe) begin n_fail++; $display("FAIL hit_prompt: got %0d expected %0d", pr, pe); end
  endtask

  task automatic test_penalty();
    logic [2:0] he, ha, pads;
    logic [7:0] sc;
    logic [1:0] pr, pe, p;
    for (int k = 0; k < 2; k++) begin
      p = bus.prompt_o;
      pads = pad_of(2'((p % 2'd3) + 2'd1));
      strike(pads, he, ha, sc, pr, pe);
`ifdef DRUM_PENALTY_EN
      exp_score = (exp_score > 0) ? exp_score - 1 : 0;
`endif
      n_tests++; if (ha !== pads) begin n_fail++; $display("FAIL wrong_pulse: got %b expected %b", ha, pads); end
      n_tests++; if (sc !== 8'(exp_score)) begin n_fail++; $display("FAIL wrong_score: got %0d expected %0d", sc, exp_score); end
      n_tests++; if (pr !== p) begin n_fail++; $display("FAIL wrong_prompt_kept: got %0d expected %0d", pr, p); end
    end
  endtask

  task automatic test_priority();
    logic [2:0] he, ha;
    logic [7:0] sc;
    logic [1:0] pr, pe, p;
    p = bus.prompt_o;
    strike(3'b111, he, ha, sc, pr, pe);
    if (p == 2'd1) exp_score = exp_score + 1;
`ifdef DRUM_PENALTY_EN
    else exp_score = (exp_score > 0) ? exp_score - 1 : 0;
`endif
    n_tests++; if (ha !== 3'b001) begin n_fail++; $display("FAIL priority_pulse: got %b expected 001", ha); end
    n_tests++; if (sc !== 8'(exp_score)) begin n_fail++; $display("FAIL priority_score: got %0d expected %0d", sc, exp_score); end
  endtask

  task automatic test_round_over();
    @(negedge clk); bus.seconds_i = 6'd29;
    @(posedge clk);
    @(negedge clk);
    n_tests++; if (bus.state_o !== 2'd2) begin n_fail++; $display("FAIL over_at_29: got %0d expected 2", bus.state_o); end
    bus.seconds_i = 6'd30;
    @(posedge clk);
    @(negedge clk);
    n_tests++; if (bus.state_o !== 2'd3) begin n_fail++; $display("FAIL over_state: got %0d expected 3", bus.state_o); end
    n_tests++; if (bus.prompt_o !== 2'd0) begin n_fail++; $display("FAIL over_prompt: got %0d expected 0", bus.prompt_o); end
    n_tests++; if ({bus.timer_reset_o, bus.timer_enable_o, bus.game_over_o} !== 3'b001) begin
      n_fail++; $display("FAIL over_ctrl: got %b expected 001", {bus.timer_reset_o, bus.timer_enable_o, bus.game_over_o}); end
    repeat (5) @(posedge clk);
    @(negedge clk);
    n_tests++; if (bus.score_o !== 8'(exp_score)) begin n_fail++; $display("FAIL over_score_held: got %0d expected %0d", bus.score_o, exp_score); end
    bus.seconds_i = 6'd0;
  endtask

  task automatic test_restart();
    logic [1:0] st6, st7, st8, pr8, pe8;
    logic tr7, tr8, te8;
    start_round(st6, st7, tr7, st8, tr8, te8, pr8, pe8);
    exp_score = 0;
    n_tests++; if ({st6, st7, st8} !== {2'd3, 2'd1, 2'd2}) begin
      n_fail++; $display("FAIL restart_states: got %0d,%0d,%0d expected 3,1,2", st6, st7, st8); end
    n_tests++; if (pr8 !== pe8) begin n_fail++; $display("FAIL restart_prompt: got %0d expected %0d", pr8, pe8); end
    n_tests++; if ({bus.score_o, bus.miss_o} !== 16'd0) begin
      n_fail++; $display("FAIL restart_clear: got score %0d miss %0d expected 0 0", bus.score_o, bus.miss_o); end
  endtask

  task automatic test_glitch();
    logic [2:0] seen;
    for (int i = 0; i < 3; i++) begin
      seen = 3'b000;
      @(negedge clk);
      {bus.tom_hit_i, bus.cymbal_hit_i, bus.hat_hit_i} = 3'(1 << i);
      repeat (2) @(posedge clk);
      @(negedge clk);
      {bus.tom_hit_i, bus.cymbal_hit_i, bus.hat_hit_i} = 3'b000;
      repeat (10) begin @(posedge clk); @(negedge clk); seen = seen | bus.hit_o; end
      n_tests++; if (seen !== 3'b000) begin n_fail++; $display("FAIL glitch_pad%0d: got %b expected 000", i, seen); end
    end
  endtask

  task automatic test_reset_mid();
    logic [2:0] he, ha;
    logic [7:0] sc;
    logic [1:0] pr, pe;
    logic [25:0] v;
    for (int k = 0; k < 5; k++) strike(pad_of(bus.prompt_o), he, ha, sc, pr, pe);
    n_tests++; if (bus.score_o !== 8'd5) begin n_fail++; $display("FAIL five_hits: got %0d expected 5", bus.score_o); end
    @(negedge clk); reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    v = out_vec();
    n_tests++; if (v !== RESET_VEC) begin n_fail++; $display("FAIL reset_mid_play: got %h expected %h", v, RESET_VEC); end
    reset = 1'b0;
  endtask

  task automatic test_saturation();
    logic [1:0] st6, st7, st8, pr8, pe8;
    logic tr7, tr8, te8;
    logic [2:0] he, ha;
    logic [7:0] sc;
    logic [1:0] pr, pe;
    int bad;
    start_round(st6, st7, tr7, st8, tr8, te8, pr8, pe8);
    n_tests++; if ({st6, st7, st8} !== {2'd0, 2'd1, 2'd2}) begin
      n_fail++; $display("FAIL sat_start: got %0d,%0d,%0d expected 0,1,2", st6, st7, st8); end
    bad = 0;
    for (int k = 0; k < 256; k++) begin
      strike(pad_of(bus.prompt_o), he, ha, sc, pr, pe);
      if (sc !== 8'((k < 255) ? k + 1 : 255) || pr !== pe) bad++;
    end
    n_tests++; if (bad !== 0) begin n_fail++; $display("FAIL sat_sequence: got %0d bad hits expected 0", bad); end
    n_tests++; if (bus.score_o !== 8'd255) begin n_fail++; $display("FAIL sat_score: got %0d expected 255", bus.score_o); end
    n_tests++; if (bus.miss_o !== 8'd0) begin n_fail++; $display("FAIL sat_miss: got %0d expected 0", bus.miss_o); end
  endtask

  initial begin
    test_reset();
    test_start();
    test_miss();
    test_hit();
    test_penalty();
    test_priority();
    test_round_over();
    test_restart();
    test_glitch();
    test_reset_mid();
    test_saturation();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
